md_iter_divider: RTL

- Radix-2 iterative restoring divider for DIV/DIVU. Feeds quotient/remainder into the multiply-divide unit's HI (remainder) and LO (quotient) registers.
- Issued from EX with operands rs/rt. Asserts busy so the hazard unit stalls HI/LO readers.
- Signals a one-cycle done pulse; the consumer latches LO<=quotient and HI<=remainder on that pulse.

---
 rtl/md_iter_divider.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/md_iter_divider.sv
// rtl/md_iter_divider.sv - radix-2 restoring DIV/DIVU unit feeding HI (remainder) and LO (quotient)
module md_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift, trial;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start && !flush) state_d = S_CALC;
            S_CALC: begin
                if (flush)              state_d = S_IDLE;
                else if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX:   state_d = flush ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Magnitudes: 0x80..0 negates to itself, which is the right unsigned magnitude.
    always_comb begin
        a_neg     = is_signed & dividend[WIDTH-1];
        b_neg     = is_signed & divisor[WIDTH-1];
        a_mag     = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        b_mag     = b_neg ? (~divisor + WIDTH'(1)) : divisor;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        qout_d = qout_q;
        rout_d = rout_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d   = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    dz_d   = (divisor == '0);
                    dvs_d  = b_mag;
                    quo_d  = a_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                end
            end
            S_CALC: begin
                if (!flush) begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                if (!flush) begin
                    // Divide by zero must report all ones regardless of sign fix-up.
                    if (dz_q)        qout_d = '1;
                    else if (negq_q) qout_d = ~quo_q + WIDTH'(1);
                    else             qout_d = quo_q;
                    rout_d = negr_q ? (~rem_q + WIDTH'(1)) : rem_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_CALC) || (state_q == S_FIX);
        done      = (state_q == S_DONE);
        quotient  = qout_q;
        remainder = rout_q;
    end

endmodule
